nemu_packet_source: RTL and testbench

- Per-node traffic generator; the transmit end of the packet path whose receive end is the node packet sink.
- Generates packets at a programmable Bernoulli rate to pseudo-random destinations, excluding its own node.
- Stamps each packet with the global timestamp so the sink can compute latency.
- Buffers packets in a local source-queue FIFO and injects them into the network under `i_net_full` backpressure.
- Reports generated, dropped and injected counts, plus a sticky overflow error.

---
 rtl/nemu_packet_source.sv | 153 +++++++++++++++
 tb/tb_nemu_packet_source.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nemu_packet_source.sv
// Per-node traffic generator. It creates Bernoulli-rate packets to random
// destinations other than this node, queues them in a small source FIFO and
// injects them into the network under one-cycle-lookahead backpressure.

package nemu_pkg;
  typedef struct packed {
    logic        valid;
    logic [7:0]  source;
    logic [7:0]  dest;
    logic [31:0] data;
  } packet_t;
endpackage

module nemu_packet_source
  import nemu_pkg::*;
#(
  parameter int unsigned NODE_ID    = 0,
  parameter int unsigned PORTS      = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        reset_n,
  input  logic        i_enable,
  input  logic [7:0]  i_rate,
  input  logic [15:0] i_pkt_limit,
  input  logic [31:0] i_timestamp,
  input  logic        i_net_full,
  output packet_t     o_pkt_tx,
  output logic        o_busy,
  output logic [31:0] o_gen_count,
  output logic [31:0] o_tx_count,
  output logic [15:0] o_drop_count,
  output logic        o_fifo_error
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam logic [15:0] SEED   = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [7:0]  PORTS_B = 8'(PORTS);
  localparam logic [7:0]  NODE_B  = 8'(NODE_ID);
  localparam logic [7:0]  NEXT_B  = 8'((NODE_ID + 1) % PORTS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic        lfsr_fb;
  packet_t     mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic        under_limit, limit_hit;
  logic        gen, pop, push, drop;
  logic [7:0]  dest_raw, dest;
  packet_t     new_pkt;

  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A non-zero limit stops generation once it is reached; the FSM leaves RUN
  // in the same cycle as the final generate.
  assign under_limit = (i_pkt_limit == 16'd0) || (o_gen_count < {16'd0, i_pkt_limit});
  assign limit_hit   = (i_pkt_limit != 16'd0) &&
                       ((o_gen_count + {31'd0, gen}) >= {16'd0, i_pkt_limit});

  assign gen  = (state == RUN) && i_enable && under_limit && (lfsr[7:0] < i_rate);
  // Pop only reads stored entries, so an empty queue never forwards a
  // same-cycle push.
  assign pop  = !fifo_empty && !i_net_full;
  assign push = gen && (!fifo_full || pop);
  assign drop = gen && fifo_full && !pop;

  assign dest_raw = lfsr[15:8] % PORTS_B;
  assign o_busy   = (state != IDLE);

  // Build the candidate packet; a destination equal to this node is remapped.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dest = dest_raw;
    if (dest_raw == NODE_B) dest = NEXT_B;
    new_pkt        = '0;
    new_pkt.valid  = 1'b1;
    new_pkt.source = NODE_B;
    new_pkt.dest   = dest;
    new_pkt.data   = i_timestamp;
  end

  // Run-control FSM, LFSR and the statistics counters.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      lfsr         <= SEED;
      o_gen_count  <= '0;
      o_tx_count   <= '0;
      o_drop_count <= '0;
      o_fifo_error <= 1'b0;
    end else begin
      unique case (state)
        IDLE:    if (i_enable) state <= RUN;
        RUN:     if (!i_enable || limit_hit) state <= DRAIN;
        DRAIN:   if (fifo_empty && !pop) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (state == RUN) lfsr <= {lfsr[14:0], lfsr_fb};

      if (state == IDLE && i_enable) begin
        o_gen_count  <= '0;
        o_tx_count   <= '0;
        o_drop_count <= '0;
        o_fifo_error <= 1'b0;
      end else begin
        if (gen) o_gen_count <= o_gen_count + 32'd1;
        if (pop) o_tx_count  <= o_tx_count + 32'd1;
        if (drop) begin
          if (o_drop_count != 16'hFFFF) o_drop_count <= o_drop_count + 16'd1;
          o_fifo_error <= 1'b1;
        end
      end
    end
  end

  // Source-queue pointers; the extra MSB tells full from empty.
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Source-queue storage.
  // NOTE: storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= new_pkt;
  end

  // Network output register; only valid drops when nothing is popped.
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      o_pkt_tx <= '0;
    end else if (pop) begin
      o_pkt_tx <= mem[rd_ptr[AW-1:0]];
    end else begin
      o_pkt_tx.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nemu_packet_source.sv
// Self-checking bench for nemu_packet_source: a queue-based reference model
// predicts every output cycle by cycle; directed phases add literal checks.

module tb_nemu_packet_source;
  import nemu_pkg::*;

  localparam int unsigned NODE_ID    = 2;
  localparam int unsigned PORTS      = 4;
  localparam int unsigned FIFO_DEPTH = 8;

  logic        i_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_enable = 1'b0;
  logic [7:0]  i_rate = 8'd0;
  logic [15:0] i_pkt_limit = 16'd0;
  logic [31:0] i_timestamp = 32'h1000_0000;
  logic        i_net_full = 1'b0;
  packet_t     o_pkt_tx;
  logic        o_busy;
  logic [31:0] o_gen_count, o_tx_count;
  logic [15:0] o_drop_count;
  logic        o_fifo_error;

  nemu_packet_source #(
    .NODE_ID(NODE_ID), .PORTS(PORTS), .FIFO_DEPTH(FIFO_DEPTH), .LFSR_SEED(16'hACE1)
  ) dut (
    .i_clk(i_clk), .reset_n(reset_n), .i_enable(i_enable), .i_rate(i_rate),
    .i_pkt_limit(i_pkt_limit), .i_timestamp(i_timestamp), .i_net_full(i_net_full),
    .o_pkt_tx(o_pkt_tx), .o_busy(o_busy), .o_gen_count(o_gen_count),
    .o_tx_count(o_tx_count), .o_drop_count(o_drop_count), .o_fifo_error(o_fifo_error)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed traffic
  packet_t tx_log[$];
  int      hist[PORTS];
  int      bad_src = 0;

  // Reference model state
  typedef enum {M_IDLE, M_RUN, M_DRAIN} mode_e;
  mode_e       m_mode;
  logic [15:0] m_lfsr;
  packet_t     m_q[$];
  packet_t     m_out;
  logic [31:0] m_gen, m_tx;
  logic [15:0] m_drop;
  logic        m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_lfsr = 16'hACE1;
    m_q.delete();
    m_out  = '0;
    m_gen  = 0;
    m_tx   = 0;
    m_drop = 0;
    m_err  = 0;
  endtask

  // One clock of the specification's rules, using the inputs seen at the edge.
  task automatic model_step();
    mode_e   was;
    bit      full, pop, gen;
    int      d;
    packet_t p;
    was  = m_mode;
    full = (m_q.size() == FIFO_DEPTH);
    pop  = (m_q.size() != 0) && !i_net_full;
    gen  = 0;
    p    = '0;
    if (was == M_IDLE && i_enable) begin
      m_mode = M_RUN;
      m_gen = 0; m_tx = 0; m_drop = 0; m_err = 0;
    end
    if (was == M_RUN) begin
      gen = i_enable && (i_pkt_limit == 0 || m_gen < {16'd0, i_pkt_limit}) &&
            (m_lfsr[7:0] < i_rate);
      d = int'(m_lfsr[15:8]) % PORTS;
      if (d == NODE_ID) d = (NODE_ID + 1) % PORTS;
      p.valid  = 1'b1;
      p.source = 8'(NODE_ID);
      p.dest   = 8'(d);
      p.data   = i_timestamp;
      m_lfsr = lfsr_next(m_lfsr);
    end
    if (pop) begin
      m_out = m_q.pop_front();
      m_out.valid = 1'b1;
      m_tx++;
    end else begin
      m_out.valid = 1'b0;
    end
    if (gen) begin
      m_gen++;
      if (full && !pop) begin
        if (m_drop != 16'hFFFF) m_drop++;
        m_err = 1'b1;
      end else begin
        m_q.push_back(p);
      end
    end
    if (was == M_RUN && (!i_enable || (i_pkt_limit != 0 && m_gen >= {16'd0, i_pkt_limit})))
      m_mode = M_DRAIN;
    if (was == M_DRAIN && m_q.size() == 0 && !pop)
      m_mode = M_IDLE;
  endtask

  task automatic compare_outputs();
    check("pkt_tx",     o_pkt_tx,     m_out);
    check("busy",       o_busy,       m_mode != M_IDLE);
    check("gen_count",  o_gen_count,  m_gen);
    check("tx_count",   o_tx_count,   m_tx);
    check("drop_count", o_drop_count, m_drop);
    check("fifo_error", o_fifo_error, m_err);
    if (o_pkt_tx.valid) begin
      tx_log.push_back(o_pkt_tx);
      if (o_pkt_tx.dest < PORTS) hist[o_pkt_tx.dest]++;
      if (o_pkt_tx.source != NODE_ID) bad_src++;
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    if (!reset_n) model_reset();
    else model_step();
    @(negedge i_clk);
    compare_outputs();
    i_timestamp = i_timestamp + 1;
  endtask

  task automatic wait_model_drain(input int budget);
    for (int i = 0; i < budget && m_mode != M_DRAIN; i++) tick();
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && o_busy; i++) tick();
    check(name, o_busy, 1'b0);
  endtask

  initial begin
    int base;
    logic [15:0] drop_before;
    model_reset();
    i_timestamp = 32'h1000_0000 + $urandom_range(0, 1000);

    // Reset values
    repeat (3) tick();
    check("rst_pkt", o_pkt_tx, 49'd0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_gen", o_gen_count, 32'd0);
    check("rst_err", o_fifo_error, 1'b0);
    reset_n = 1'b1;
    tick();

    // Limited run at full rate, no backpressure
    tx_log.delete();
    i_rate = 8'd255; i_pkt_limit = 16'd5; i_enable = 1'b1;
    wait_model_drain(50);
    i_enable = 1'b0;
    wait_idle("limit_idle", 50);
    check("limit_gen", o_gen_count, 32'd5);
    check("limit_tx", o_tx_count, 32'd5);
    check("limit_log", tx_log.size(), 5);
    if (tx_log.size() >= 3) begin
      check("limit_dest0", tx_log[0].dest, 8'd0);
      check("limit_dest1", tx_log[1].dest, 8'd1);
      check("limit_dest2", tx_log[2].dest, 8'd3);
      check("limit_ts_step", tx_log[1].data - tx_log[0].data, 32'd1);
      check("limit_src", tx_log[0].source, 8'd2);
    end

    // Zero rate never generates
    tx_log.delete();
    i_rate = 8'd0; i_pkt_limit = 16'd0; i_enable = 1'b1;
    repeat (1000) tick();
    check("rate0_gen", o_gen_count, 32'd0);
    check("rate0_busy", o_busy, 1'b1);
    check("rate0_log", tx_log.size(), 0);
    i_enable = 1'b0;
    repeat (2) tick();
    check("rate0_idle", o_busy, 1'b0);

    // Overflow under held backpressure, then release
    i_rate = 8'd255; i_pkt_limit = 16'd20; i_net_full = 1'b1; i_enable = 1'b1;
    wait_model_drain(100);
    i_enable = 1'b0;
    repeat (3) tick();
    check("ovf_gen", o_gen_count, 32'd20);
    check("ovf_drop", o_drop_count, 16'd12);
    check("ovf_err", o_fifo_error, 1'b1);
    check("ovf_tx", o_tx_count, 32'd0);
    base = tx_log.size();
    i_net_full = 1'b0;
    wait_idle("ovf_idle", 50);
    check("ovf_tx_after", o_tx_count, 32'd8);
    check("ovf_log", tx_log.size() - base, 8);

    // Full queue with a pop in the same cycle as a generate
    i_pkt_limit = 16'd0; i_net_full = 1'b1; i_enable = 1'b1;
    for (int i = 0; i < 30 && m_q.size() != FIFO_DEPTH; i++) tick();
    tick();
    drop_before = m_drop;
    i_net_full = 1'b0;
    tick();
    check("fullpop_drop", o_drop_count, drop_before);
    i_enable = 1'b0;
    wait_idle("fullpop_idle", 50);

    // Destination histogram over 10000 generates
    for (int i = 0; i < PORTS; i++) hist[i] = 0;
    bad_src = 0;
    i_rate = 8'd255; i_pkt_limit = 16'd10000; i_enable = 1'b1;
    wait_model_drain(11000);
    i_enable = 1'b0;
    wait_idle("hist_idle", 50);
    check("hist_gen", o_gen_count, 32'd10000);
    check("hist_tx", o_tx_count, 32'd10000);
    check("hist_self", hist[2], 0);
    check("hist_d0_seen", hist[0] > 0, 1'b1);
    check("hist_d1_seen", hist[1] > 0, 1'b1);
    check("hist_d3_seen", hist[3] > 0, 1'b1);
    check("hist_src", bad_src, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        i_rate = 8'($urandom);
        i_pkt_limit = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
      end
      if ($urandom_range(0, 49) == 0) i_enable = ~i_enable;
      i_net_full = ($urandom_range(0, 3) == 0);
      tick();
    end
    i_enable = 1'b0; i_net_full = 1'b0;
    wait_idle("rand_idle", 50);

    // Reset in the middle of a drain with packets queued
    i_rate = 8'd255; i_pkt_limit = 16'd3; i_net_full = 1'b1; i_enable = 1'b1;
    wait_model_drain(50);
    i_enable = 1'b0;
    i_net_full = 1'b0;
    tick();
    check("drain_pop_valid", o_pkt_tx.valid, 1'b1);
    i_net_full = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", o_pkt_tx.valid, 1'b0);
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_gen", o_gen_count, 32'd0);
    check("mid_rst_tx", o_tx_count, 32'd0);
    check("mid_rst_drop", o_drop_count, 16'd0);
    model_reset();
    @(negedge i_clk);
    reset_n = 1'b1;
    i_net_full = 1'b0;
    tx_log.delete();
    repeat (10) tick();
    check("post_rst_log", tx_log.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
